slurm_cpu_hazard_scoreboard: RTL

- Parametrised successor to the CPU hazard unit.
- Owns an internal DEPTH-stage scoreboard of in-flight destination registers and flag writers; the pipeline module no longer passes hazard registers in and out.
- Per-stage masks set which stages stall, which stages forward, and which stages block flag-dependent branches.
- Adds nearest-writer forwarding select, stall pulses, a saturating stall counter and load_pc flush.

---
 rtl/slurm_cpu_hazard_scoreboard.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/slurm_cpu_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// slurm_cpu_hazard_scoreboard
//
// Tracks the destination registers and flag writers of the DEPTH instructions
// in flight beyond p0 and decides, for the instruction currently in p0,
// whether to forward each operand, stall the pipeline, or do nothing.
//
// Ports:
//   CLK, RST         clock, asynchronous active-high reset
//   is_executing     pipeline advances this cycle
//   load_pc          branch taken: flush all tracked entries
//   p0_*             description of the instruction in slot p0
//   regA_sel0/B      p0 source registers
//   stall            hold p0 and insert a bubble (combinational)
//   stall_start/end  first stalled cycle / first cycle after a stall
//   fwd_a/b_valid    operand comes from the forwarding network
//   fwd_a/b_sel      forwarding source stage, 1..DEPTH (0 when not forwarding)
//   stall_count      saturating count of stalled cycles
//
// state   | meaning
// --------+------------------------------------------------
// RUN     | pipeline flowing, no stall seen last cycle
// STALLED | previous cycle stalled (or held while stalled)
// ---------------------------------------------------------------------------
module slurm_cpu_hazard_scoreboard #(
  parameter int                 REGISTER_BITS = 4,
  parameter int                 DEPTH         = 4,
  parameter logic [DEPTH-1:0]   STALL_MASK    = 4'b0010,
  parameter logic [DEPTH-1:0]   FWD_MASK      = 4'b0001,
  parameter logic [DEPTH-1:0]   FLAG_MASK     = 4'b0111,
  parameter int                 CNT_BITS      = 8,
  localparam int                SEL_W         = $clog2(DEPTH + 1)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     is_executing,
  input  logic                     load_pc,
  input  logic                     p0_valid,
  input  logic                     p0_wr_en,
  input  logic [REGISTER_BITS-1:0] p0_wr_reg,
  input  logic                     p0_wr_flags,
  input  logic                     p0_uses_flags,
  input  logic [REGISTER_BITS-1:0] regA_sel0,
  input  logic [REGISTER_BITS-1:0] regB_sel0,
  output logic                     stall,
  output logic                     stall_start,
  output logic                     stall_end,
  output logic                     fwd_a_valid,
  output logic [SEL_W-1:0]         fwd_a_sel,
  output logic                     fwd_b_valid,
  output logic [SEL_W-1:0]         fwd_b_sel,
  output logic [CNT_BITS-1:0]      stall_count
);

  typedef enum logic {RUN, STALLED} state_t;

  state_t                     state;
  logic [DEPTH:1]             sb_valid;
  logic [DEPTH:1]             sb_flags;
  logic [REGISTER_BITS-1:0]   sb_reg [1:DEPTH];

  logic found_a, found_b, hz_a, hz_b, flag_any, hazard;

  // Nearest-writer scan: the first matching stage decides; older stages
  // holding the same register are ignored.
  always_comb begin
    found_a     = 1'b0;
    found_b     = 1'b0;
    hz_a        = 1'b0;
    hz_b        = 1'b0;
    flag_any    = 1'b0;
    fwd_a_valid = 1'b0;
    fwd_a_sel   = '0;
    fwd_b_valid = 1'b0;
    fwd_b_sel   = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (!found_a && regA_sel0 != '0 && sb_valid[k] && sb_reg[k] == regA_sel0) begin
        found_a = 1'b1;
        if (FWD_MASK[k-1]) begin
          fwd_a_valid = 1'b1;
          fwd_a_sel   = SEL_W'(k);
        end else if (STALL_MASK[k-1]) begin
          hz_a = 1'b1;
        end
      end
      if (!found_b && regB_sel0 != '0 && sb_valid[k] && sb_reg[k] == regB_sel0) begin
        found_b = 1'b1;
        if (FWD_MASK[k-1]) begin
          fwd_b_valid = 1'b1;
          fwd_b_sel   = SEL_W'(k);
        end else if (STALL_MASK[k-1]) begin
          hz_b = 1'b1;
        end
      end
      if (sb_valid[k] && sb_flags[k] && FLAG_MASK[k-1]) begin
        flag_any = 1'b1;
      end
    end
  end

  assign hazard      = p0_valid && (hz_a || hz_b || (p0_uses_flags && flag_any));
  assign stall       = hazard && is_executing && !load_pc;
  assign stall_start = stall && (state == RUN);
  assign stall_end   = (state == STALLED) && !stall && is_executing;

  // Scoreboard shift register. A stall pushes a bubble so the writer drains
  // past the stalling stages and the stall resolves by itself.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sb_valid <= '0;
      sb_flags <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        sb_reg[k] <= '0;
      end
    end else if (load_pc) begin
      sb_valid <= '0;
    end else if (is_executing) begin
      for (int k = DEPTH; k >= 2; k--) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_flags[k] <= sb_flags[k-1];
        sb_reg[k]   <= sb_reg[k-1];
      end
      sb_valid[1] <= p0_valid && !stall;
      sb_flags[1] <= p0_wr_flags && !stall;
      sb_reg[1]   <= (p0_wr_en && !stall) ? p0_wr_reg : '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= RUN;
      stall_count <= '0;
    end else if (load_pc) begin
      state <= RUN;
    end else begin
      if (stall && stall_count != '1) begin
        stall_count <= stall_count + 1'b1;
      end
      case (state)
        RUN:     if (stall) state <= STALLED;
        STALLED: if (!stall && is_executing) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule
